prog_load_sequencer: RTL and testbench
======================================

// Module: prog_load_sequencer
// PURPOSE
// - Writer side of the program-memory load path and the source of the 2-bit State bus
//   (LOAD=00, FETCH=01, DECODE=10, EXECUTE=11) that the control unit decodes.
// - Accepts a byte stream over a valid/ready handshake and packs two bytes into each
//   12-bit instruction word.
// - Writes each word to program memory at consecutive addresses.
// - After the last word it releases the core: State cycles FETCH->DECODE->EXECUTE.
// PARAMETERS
// - ADDR_W  8   program-memory address width; DEPTH = 2**ADDR_W words
// - WORD_W  12  instruction width; fixed at 12, other values unsupported
// PORTS
// - clk              in   1         single clock, rising edge
// - rst_n            in   1         asynchronous, active-low reset
// - Load_Start       in   1         one-cycle request to begin loading
// - Load_Len         in   ADDR_W+1  number of words to load; sampled with Load_Start
// - Byte_In          in   8         stream byte
// - Byte_Valid       in   1         Byte_In is valid
// - Byte_Ready       out  1         sequencer can accept a byte
// - ProgMem_WrEn     out  1         one-cycle program-memory write strobe
// - ProgMem_WrAddr   out  ADDR_W    write address
// - ProgMem_WrData   out  12        write data
// - State            out  2         core phase, to the control unit
// - Load_Done        out  1         high while running a fully loaded program
// - Load_Count       out  ADDR_W+1  words written since the last Load_Start
// - Load_Err         out  1         sticky format error (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: FSM=IDLE, State=00, Byte_Ready=0, ProgMem_WrEn=0, WrAddr=0, WrData=0,
//   Load_Done=0, Load_Count=0, Load_Err=0, low-byte holding register=0.
// - Reset is asynchronous and may occur at any point. Words already written stay in memory;
//   every register returns to its reset value.
// - FSM states: IDLE, LO, HI, RUN. State=LOAD in IDLE, LO and HI.
// - Byte_Ready is combinational: 1 exactly in LO and HI. A byte is accepted on a cycle with
//   Byte_Valid & Byte_Ready. Back-to-back acceptance is allowed with no bubbles.
// - IDLE + Load_Start:
//   - Latch len = min(Load_Len, DEPTH) and clear Load_Count, Load_Done and Load_Err.
//   - If len==0, go to RUN; State=FETCH on the next cycle.
//   - Otherwise go to LO.
// - LO + accept: latch Byte_In as the low byte, then go to HI.
// - HI + accept:
//   - The next cycle shows WrEn=1, WrData={Byte_In[3:0], low byte},
//     WrAddr=Load_Count[ADDR_W-1:0], and Load_Count increments by 1 (write latency 1 cycle).
//   - If Load_Count+1==len, go to RUN and set Load_Done; otherwise go back to LO.
// - RUN:
//   - State sequence FETCH->DECODE->EXECUTE->FETCH, one phase per clock.
//   - The first RUN cycle is always FETCH.
// - Load_Start in LO or HI: ignored; the load continues.
// - Load_Start in RUN: the run aborts at once, whatever the phase. The next cycle is
//   State=LOAD in LO, with len relatched and Load_Count=0 (reload from address 0).
// - Load_Count never exceeds DEPTH. Address DEPTH-1 is the last address written and no
//   address wrap occurs.
// - ProgMem_WrEn is never asserted in IDLE or RUN, except for the final write of a load:
//   that write lands in the first RUN cycle.
// CONFIGURATION
// - `define LOAD_CHECK_EN:
//   - In HI, an accepted byte with Byte_In[7:4]!=0 is a format error.
//   - On error: no write, Load_Count unchanged, Load_Err set (sticky until the next
//     Load_Start or reset), FSM goes to IDLE with State=LOAD, Load_Done stays 0.
// - Without LOAD_CHECK_EN: Byte_In[7:4] of the high byte is ignored and Load_Err is tied to 0.
// TESTING
// - Reset, then Load_Start with Load_Len=2 and bytes 34,01,CD,0A (Valid held high)
//   -> writes 0x134@0 and 0xACD@1. After that, Load_Done=1 and Load_Count=2.
//   State then reads 00..00,01,10,11,01,10,11...
// - Load_Len=0 -> the cycle after Load_Start shows State=01, with no WrEn and Load_Done=1.
// - Byte_Valid toggling 1,0,0,1 every cycle -> exactly one write per two accepted bytes,
//   and Byte_Ready stays 1 throughout the load.
// - rst_n low mid-load after 3 words -> all outputs at reset values in the same cycle;
//   a later Load_Start writes again from address 0.
// - Load_Start during RUN with State=DECODE -> State=00 on the next cycle and Byte_Ready=1.
//   Following bytes overwrite from address 0.
// - LOAD_CHECK_EN with high byte 0x1F -> no WrEn, Load_Err=1 and FSM in IDLE.
//   Without the macro, the same byte writes data {4'hF, low byte}.

Source files
------------

// File: rtl/prog_load_sequencer.sv
// prog_load_sequencer: writer side of the program-memory load path.
// Packs two stream bytes (low byte first, then high nibble) into 12-bit
// instruction words, writes them to consecutive addresses, then releases the
// core by cycling the State bus FETCH -> DECODE -> EXECUTE.
//
// Optional build macro: LOAD_CHECK_EN
//    When defined, a high byte with a non-zero upper nibble is rejected as a
//    format error: no write, Load_Err sets (sticky), and the sequencer idles.
//    When undefined, the upper nibble is ignored and Load_Err is tied low.
//
// FSM states:
//    state | meaning
//    IDLE  | waiting for Load_Start, State=LOAD
//    LO    | waiting for the low byte of the next word, State=LOAD
//    HI    | waiting for the high byte, write issued on accept, State=LOAD
//    RUN   | program loaded, State cycles FETCH/DECODE/EXECUTE
module prog_load_sequencer #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Load_Start,
   input  logic [ADDR_W:0]   Load_Len,
   input  logic [7:0]        Byte_In,
   input  logic              Byte_Valid,
   output logic              Byte_Ready,
   output logic              ProgMem_WrEn,
   output logic [ADDR_W-1:0] ProgMem_WrAddr,
   output logic [WORD_W-1:0] ProgMem_WrData,
   output logic [1:0]        State,
   output logic              Load_Done,
   output logic [ADDR_W:0]   Load_Count,
   output logic              Load_Err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RUN  = 2'd3
   } seqState_t;

   localparam logic [1:0] PH_LOAD    = 2'b00;
   localparam logic [1:0] PH_FETCH   = 2'b01;
   localparam logic [1:0] PH_DECODE  = 2'b10;
   localparam logic [1:0] PH_EXECUTE = 2'b11;

   // DEPTH = 2**ADDR_W, expressed in the width of the length/count registers.
   localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

   seqState_t         seqState;
   logic [ADDR_W:0]   lenReg;
   logic [7:0]        lowByte;
   logic [ADDR_W:0]   lenClamp;
   logic [ADDR_W:0]   countNext;
   logic              byteAccept;
   logic              hiNibbleBad;
   logic [1:0]        nextPhase;

   // Handshake readiness and derived load-path values.
   always_comb begin
      Byte_Ready  = (seqState == LO) || (seqState == HI);
      byteAccept  = Byte_Valid && Byte_Ready;
      lenClamp    = (Load_Len > DEPTH_V) ? DEPTH_V : Load_Len;
      countNext   = Load_Count + 1'b1;
      hiNibbleBad = (Byte_In[7:4] != 4'h0);
      nextPhase   = PH_FETCH;
      case (State)
         PH_FETCH:   nextPhase = PH_DECODE;
         PH_DECODE:  nextPhase = PH_EXECUTE;
         default:    nextPhase = PH_FETCH;
      endcase
   end

`ifdef LOAD_CHECK_EN
`else
   // Without the format check the upper nibble of the high byte carries no meaning.
   logic unusedHiNibble;
   assign unusedHiNibble = hiNibbleBad;
   assign Load_Err       = 1'b0;
`endif

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seqState       <= IDLE;
         State          <= PH_LOAD;
         ProgMem_WrEn   <= 1'b0;
         ProgMem_WrAddr <= '0;
         ProgMem_WrData <= '0;
         Load_Done      <= 1'b0;
         Load_Count     <= '0;
         lenReg         <= '0;
         lowByte        <= 8'h00;
`ifdef LOAD_CHECK_EN
         Load_Err       <= 1'b0;
`endif
      end else begin
         ProgMem_WrEn <= 1'b0;
         case (seqState)
            IDLE, RUN: begin
               if (Load_Start) begin
                  // Start from IDLE or abort a running program: reload from address 0.
                  lenReg     <= lenClamp;
                  Load_Count <= '0;
                  Load_Done  <= 1'b0;
`ifdef LOAD_CHECK_EN
                  Load_Err   <= 1'b0;
`endif
                  if (lenClamp == '0) begin
                     // Empty program: release the core immediately.
                     seqState  <= RUN;
                     State     <= PH_FETCH;
                     Load_Done <= 1'b1;
                  end else begin
                     seqState <= LO;
                     State    <= PH_LOAD;
                  end
               end else if (seqState == RUN) begin
                  State <= nextPhase;
               end
            end
            LO: begin
               if (byteAccept) begin
                  lowByte  <= Byte_In;
                  seqState <= HI;
               end
            end
            HI: begin
               if (byteAccept) begin
`ifdef LOAD_CHECK_EN
                  if (hiNibbleBad) begin
                     Load_Err <= 1'b1;
                     seqState <= IDLE;
                  end else begin
`else
                  begin
`endif
                     ProgMem_WrEn   <= 1'b1;
                     ProgMem_WrAddr <= Load_Count[ADDR_W-1:0];
                     ProgMem_WrData <= {Byte_In[3:0], lowByte};
                     Load_Count     <= countNext;
                     if (countNext == lenReg) begin
                        // Last word: its write lands in the first RUN cycle.
                        seqState  <= RUN;
                        State     <= PH_FETCH;
                        Load_Done <= 1'b1;
                     end else begin
                        seqState <= LO;
                     end
                  end
               end
            end
            default: begin
               seqState <= IDLE;
               State    <= PH_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Directed testbench for prog_load_sequencer (ADDR_W=3, so DEPTH=8).
module tb_prog_load_sequencer;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          Load_Start = 1'b0;
   logic [AW:0]   Load_Len = '0;
   logic [7:0]    Byte_In = 8'h00;
   logic          Byte_Valid = 1'b0;
   logic          Byte_Ready;
   logic          ProgMem_WrEn;
   logic [AW-1:0] ProgMem_WrAddr;
   logic [11:0]   ProgMem_WrData;
   logic [1:0]    State;
   logic          Load_Done;
   logic [AW:0]   Load_Count;
   logic          Load_Err;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] wrA[$];
   logic [11:0]   wrD[$];

   prog_load_sequencer #(.ADDR_W(AW), .WORD_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .Load_Start(Load_Start), .Load_Len(Load_Len),
      .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
      .ProgMem_WrEn(ProgMem_WrEn), .ProgMem_WrAddr(ProgMem_WrAddr),
      .ProgMem_WrData(ProgMem_WrData), .State(State), .Load_Done(Load_Done),
      .Load_Count(Load_Count), .Load_Err(Load_Err)
   );

   always #5 clk = ~clk;

   // Write log, sampled away from the rising edge.
   always @(negedge clk) begin
      if (ProgMem_WrEn) begin
         wrA.push_back(ProgMem_WrAddr);
         wrD.push_back(ProgMem_WrData);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      Load_Start = 1'b0;
      Byte_Valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      wrA.delete();
      wrD.delete();
   endtask

   task automatic startLoad(input logic [AW:0] len);
      Load_Start = 1'b1;
      Load_Len = len;
      step();
      Load_Start = 1'b0;
   endtask

   task automatic streamBytes(input logic [7:0] bs[$], input bit toggle,
                              output int nAcc, output int readyLow);
      int c = 0;
      bit acc;
      nAcc = 0;
      readyLow = 0;
      while (nAcc < bs.size() && c < 200) begin
         Byte_In = bs[nAcc];
         Byte_Valid = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         if (!Byte_Ready) readyLow++;
         acc = Byte_Valid && Byte_Ready;
         step();
         if (acc) nAcc++;
         c++;
      end
      Byte_Valid = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checks++;
      if ({State, Byte_Ready, ProgMem_WrEn, Load_Done, Load_Err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: actual=%b required=000000",
                  {State, Byte_Ready, ProgMem_WrEn, Load_Done, Load_Err});
      end
      checks++;
      if ({ProgMem_WrAddr, ProgMem_WrData, Load_Count} !== '0) begin
         errors++;
         $display("FAIL reset_data: actual addr=%h data=%h count=%h required=0",
                  ProgMem_WrAddr, ProgMem_WrData, Load_Count);
      end
   endtask

   task automatic test_basic_load();
      int n, rl;
      doReset();
      startLoad(2);
      checks++;
      if (State !== 2'b00 || Byte_Ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_loading: actual state=%b ready=%b required state=00 ready=1", State, Byte_Ready);
      end
      streamBytes('{8'h34, 8'h01, 8'hCD, 8'h0A}, 1'b0, n, rl);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL basic_accept: actual=%0d required=4", n);
      end
      checks++;
      if (ProgMem_WrEn !== 1'b1 || ProgMem_WrAddr !== 3'd1 || ProgMem_WrData !== 12'hACD) begin
         errors++;
         $display("FAIL basic_last_write: actual en=%b addr=%h data=%h required en=1 addr=1 data=acd",
                  ProgMem_WrEn, ProgMem_WrAddr, ProgMem_WrData);
      end
      checks++;
      if (State !== 2'b01 || Load_Done !== 1'b1 || Load_Count !== 4'd2) begin
         errors++;
         $display("FAIL basic_release: actual state=%b done=%b count=%0d required state=01 done=1 count=2",
                  State, Load_Done, Load_Count);
      end
      step();
      checks++;
      if (State !== 2'b10 || ProgMem_WrEn !== 1'b0) begin
         errors++;
         $display("FAIL basic_decode: actual state=%b en=%b required state=10 en=0", State, ProgMem_WrEn);
      end
      step();
      checks++;
      if (State !== 2'b11) begin
         errors++;
         $display("FAIL basic_execute: actual=%b required=11", State);
      end
      step();
      checks++;
      if (State !== 2'b01) begin
         errors++;
         $display("FAIL basic_wrap: actual=%b required=01", State);
      end
      checks++;
      if (wrA.size() !== 2) begin
         errors++;
         $display("FAIL basic_wr_count: actual=%0d required=2", wrA.size());
      end else begin
         checks++;
         if (wrA[0] !== 3'd0 || wrD[0] !== 12'h134 || wrA[1] !== 3'd1 || wrD[1] !== 12'hACD) begin
            errors++;
            $display("FAIL basic_wr_log: actual %h@%0d %h@%0d required 134@0 acd@1",
                     wrD[0], wrA[0], wrD[1], wrA[1]);
         end
      end
   endtask

   task automatic test_len_zero();
      doReset();
      startLoad(0);
      checks++;
      if (State !== 2'b01 || ProgMem_WrEn !== 1'b0 || Load_Done !== 1'b1 || Byte_Ready !== 1'b0) begin
         errors++;
         $display("FAIL len0: actual state=%b en=%b done=%b ready=%b required 01 0 1 0",
                  State, ProgMem_WrEn, Load_Done, Byte_Ready);
      end
   endtask

   task automatic test_toggle_valid();
      int n, rl;
      doReset();
      startLoad(3);
      streamBytes('{8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04}, 1'b1, n, rl);
      checks++;
      if (n !== 6 || rl !== 0) begin
         errors++;
         $display("FAIL toggle_ready: actual accepted=%0d readyLow=%0d required 6 0", n, rl);
      end
      step();
      checks++;
      if (wrA.size() !== 3 || Load_Count !== 4'd3) begin
         errors++;
         $display("FAIL toggle_writes: actual writes=%0d count=%0d required 3 3", wrA.size(), Load_Count);
      end else begin
         checks++;
         if (wrD[1] !== 12'h320 || wrA[2] !== 3'd2 || wrD[2] !== 12'h430) begin
            errors++;
            $display("FAIL toggle_data: actual %h %h@%0d required 320 430@2", wrD[1], wrD[2], wrA[2]);
         end
      end
   endtask

   task automatic test_reset_midload();
      int n, rl;
      doReset();
      startLoad(5);
      streamBytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0, n, rl);
      checks++;
      if (wrA.size() !== 3 || Load_Count !== 4'd3) begin
         errors++;
         $display("FAIL midload_progress: actual writes=%0d count=%0d required 3 3", wrA.size(), Load_Count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({State, Byte_Ready, ProgMem_WrEn, Load_Done, Load_Err} !== 6'b0 ||
          {ProgMem_WrAddr, ProgMem_WrData, Load_Count} !== '0) begin
         errors++;
         $display("FAIL midload_async_reset: actual st=%b rdy=%b en=%b done=%b addr=%h data=%h cnt=%h required all 0",
                  State, Byte_Ready, ProgMem_WrEn, Load_Done, ProgMem_WrAddr, ProgMem_WrData, Load_Count);
      end
      step();
      rst_n = 1'b1;
      startLoad(1);
      streamBytes('{8'hAA, 8'h0B}, 1'b0, n, rl);
      checks++;
      if (ProgMem_WrEn !== 1'b1 || ProgMem_WrAddr !== 3'd0 || ProgMem_WrData !== 12'hBAA || Load_Count !== 4'd1) begin
         errors++;
         $display("FAIL midload_reload: actual en=%b addr=%0d data=%h cnt=%0d required 1 0 baa 1",
                  ProgMem_WrEn, ProgMem_WrAddr, ProgMem_WrData, Load_Count);
      end
   endtask

   task automatic test_abort_run();
      int n, rl;
      doReset();
      startLoad(1);
      streamBytes('{8'h55, 8'h06}, 1'b0, n, rl);
      step();
      checks++;
      if (State !== 2'b10) begin
         errors++;
         $display("FAIL abort_precond: actual=%b required=10", State);
      end
      Load_Start = 1'b1;
      Load_Len = 2;
      step();
      Load_Start = 1'b0;
      checks++;
      if (State !== 2'b00 || Byte_Ready !== 1'b1 || Load_Count !== 4'd0 || Load_Done !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: actual st=%b rdy=%b cnt=%0d done=%b required 00 1 0 0",
                  State, Byte_Ready, Load_Count, Load_Done);
      end
      streamBytes('{8'h11, 8'h02, 8'h33, 8'h04}, 1'b0, n, rl);
      step();
      checks++;
      if (wrA.size() !== 3) begin
         errors++;
         $display("FAIL abort_wr_count: actual=%0d required=3", wrA.size());
      end else begin
         checks++;
         if (wrA[1] !== 3'd0 || wrD[1] !== 12'h211 || wrA[2] !== 3'd1 || wrD[2] !== 12'h433) begin
            errors++;
            $display("FAIL abort_overwrite: actual %h@%0d %h@%0d required 211@0 433@1",
                     wrD[1], wrA[1], wrD[2], wrA[2]);
         end
      end
   endtask

   task automatic test_depth_clamp();
      int n, rl;
      logic [7:0] bs[$];
      doReset();
      for (int i = 0; i < 8; i++) begin
         bs.push_back(8'h10 + 8'(i));
         bs.push_back(8'(i));
      end
      startLoad(4'd15);
      streamBytes(bs, 1'b0, n, rl);
      checks++;
      if (n !== 16 || Load_Count !== 4'd8 || ProgMem_WrAddr !== 3'd7 || ProgMem_WrData !== 12'h717) begin
         errors++;
         $display("FAIL depth_last: actual acc=%0d cnt=%0d addr=%0d data=%h required 16 8 7 717",
                  n, Load_Count, ProgMem_WrAddr, ProgMem_WrData);
      end
      checks++;
      if (State !== 2'b01 || Load_Done !== 1'b1 || Byte_Ready !== 1'b0) begin
         errors++;
         $display("FAIL depth_release: actual st=%b done=%b rdy=%b required 01 1 0", State, Load_Done, Byte_Ready);
      end
   endtask

   task automatic test_format();
      int n, rl;
      doReset();
      startLoad(2);
      streamBytes('{8'h22, 8'h1F}, 1'b0, n, rl);
`ifdef LOAD_CHECK_EN
      checks++;
      if (ProgMem_WrEn !== 1'b0 || Load_Err !== 1'b1 || Load_Count !== 4'd0 || Load_Done !== 1'b0) begin
         errors++;
         $display("FAIL format_err: actual en=%b err=%b cnt=%0d done=%b required 0 1 0 0",
                  ProgMem_WrEn, Load_Err, Load_Count, Load_Done);
      end
      step();
      checks++;
      if (Byte_Ready !== 1'b0 || State !== 2'b00 || Load_Err !== 1'b1) begin
         errors++;
         $display("FAIL format_idle: actual rdy=%b st=%b err=%b required 0 00 1", Byte_Ready, State, Load_Err);
      end
`else
      checks++;
      if (ProgMem_WrEn !== 1'b1 || ProgMem_WrData !== 12'hF22 || ProgMem_WrAddr !== 3'd0 || Load_Err !== 1'b0) begin
         errors++;
         $display("FAIL format_nocheck: actual en=%b data=%h addr=%0d err=%b required 1 f22 0 0",
                  ProgMem_WrEn, ProgMem_WrData, ProgMem_WrAddr, Load_Err);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_len_zero();
      test_toggle_valid();
      test_reset_midload();
      test_abort_run();
      test_depth_clamp();
      test_format();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
